lsb_mem_unit: RTL

- Sits directly downstream of the load/store buffer. Accepts one load or store request at a time.
- Performs the access over the byte-serial RAM/IO bus (8-bit data, 1-cycle read latency).
- Returns the load value, sign/zero-extended, or a store-done pulse tagged with the RoB id. The RoB and RS consume it on the LSB broadcast path.

---
 rtl/lsb_mem_unit_pkg.sv | 46 ++++
 rtl/lsb_mem_unit_if.sv | 57 +++++
 rtl/lsb_mem_extend.sv | 33 +++
 rtl/lsb_mem_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lsb_mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_unit_pkg
// Purpose  : Shared constants, types and helpers for the LSB memory unit:
//            RoB tag width, access-size encodings, I/O base address, FSM
//            state type and size/alignment helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package lsb_mem_unit_pkg;

  localparam int          ROB_SIZE_WIDTH  = 4;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  // Size code 3 is illegal and handled exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? MEM_W : size;
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_unit_if
// Purpose  : Request / response / byte-bus bundle of the LSB memory unit.
//            slave  = view of the memory unit itself.
//            master = view of the surroundings (LSB, RoB, RAM/IO bus).
// Signals  : req_* (request handshake), flush, mem_* / io_buffer_full
//            (byte-serial bus), resp_* (broadcast completion).
// Options  : MEM_MISALIGN_CHECK_EN adds resp_err.
// Revision : 1.0 - initial release
// ============================================================================
interface lsb_mem_unit_if #(
  parameter int ROB_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic [ROB_W-1:0] req_rob_id;
  logic             flush;
  logic [7:0]       mem_din;
  logic             io_buffer_full;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             resp_valid;
  logic [ROB_W-1:0] resp_rob_id;
  logic [31:0]      resp_value;
`ifdef MEM_MISALIGN_CHECK_EN
  logic             resp_err;
`endif

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr,
           req_data, req_rob_id, flush, mem_din, io_buffer_full,
    output req_ready, mem_dout, mem_a, mem_wr, resp_valid, resp_rob_id,
           resp_value
`ifdef MEM_MISALIGN_CHECK_EN
    , output resp_err
`endif
  );

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr,
           req_data, req_rob_id, flush, mem_din, io_buffer_full,
    input  req_ready, mem_dout, mem_a, mem_wr, resp_valid, resp_rob_id,
           resp_value
`ifdef MEM_MISALIGN_CHECK_EN
    , input resp_err
`endif
  );

endinterface
`default_nettype wire

// File: rtl/lsb_mem_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_extend
// Purpose  : Combinational size / sign extension of the assembled load word.
// Ports    : data_in     - little-endian assembled bytes
//            size        - MEM_B / MEM_H / other = word
//            is_unsigned - zero-extend instead of sign-extend
//            value       - extended result
// Revision : 1.0 - initial release
// ============================================================================
module lsb_mem_extend
  import lsb_mem_unit_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);
  logic sign_b;
  logic sign_h;

  always_comb begin
    sign_b = data_in[7]  & ~is_unsigned;
    sign_h = data_in[15] & ~is_unsigned;
    case (size)
      MEM_B:   value = {{24{sign_b}}, data_in[7:0]};
      MEM_H:   value = {{16{sign_h}}, data_in[15:0]};
      default: value = data_in;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsb_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_unit
// Purpose  : Executes one load or store from the load/store buffer over the
//            byte-serial RAM/IO bus and broadcasts the tagged completion.
// Ports    : clk  - system clock
//            rst  - synchronous reset, active low
//            rdy  - global enable, 0 freezes everything
//            bus  - lsb_mem_unit_if.slave (request, flush, byte bus, response)
// Options  : MEM_MISALIGN_CHECK_EN - misaligned half/word accesses are
//            answered with 32'hDEAD_BEEF and resp_err instead of bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module lsb_mem_unit
  import lsb_mem_unit_pkg::*;
#(
  parameter int          ROB_W   = ROB_SIZE_WIDTH,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  lsb_mem_unit_if.slave bus
);
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_nx, nbytes;
  logic [31:0]      addr_q, data_buf, load_buf, ext_value;
  logic [1:0]       size_q, capt_idx;
  logic             uns_q;
  logic [ROB_W-1:0] tag_q, resp_tag_q;
  logic [31:0]      mem_a_q, resp_value_q;
  logic [7:0]       mem_dout_q;
  logic             mem_wr_q, resp_valid_q;
  logic             idle, accept, misalign_req, io_stall, last_done;

`ifdef MEM_MISALIGN_CHECK_EN
  logic resp_err_q;
  assign misalign_req = is_misaligned(norm_size(bus.req_size), bus.req_addr[1:0]);
  assign bus.resp_err = resp_err_q;
`else
  assign misalign_req = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst)     state_q <= ST_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !misalign_req)
                  state_d = bus.req_is_store ? ST_STORE : ST_LOAD;
      ST_LOAD:  if (bus.flush || last_done) state_d = ST_IDLE;
      ST_STORE: if (last_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    idle      = (state_q == ST_IDLE);
    // A load offered during a flush belongs to the squashed path; stores are
    // already committed and are taken regardless.
    accept    = rdy && idle && bus.req_valid && !(bus.flush && !bus.req_is_store);
    nbytes    = size_bytes(size_q);
    cnt_nx    = cnt_q + 3'd1;
    // Load: count reaches N when the last byte is on mem_din.
    // Store: count reaches N once all bytes have been driven.
    last_done = (cnt_q == nbytes);
    io_stall  = (addr_q >= IO_BASE) && bus.io_buffer_full;
    // mem_din carries the byte addressed one cycle earlier, i.e. byte cnt-1.
    capt_idx  = cnt_q[1:0] - 2'd1;
    load_buf  = data_buf;
    load_buf[{capt_idx, 3'b000} +: 8] = bus.mem_din;
  end

  assign bus.req_ready   = idle;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rob_id = resp_tag_q;
  assign bus.resp_value  = resp_value_q;

  lsb_mem_extend u_extend (
    .data_in     (load_buf),
    .size        (size_q),
    .is_unsigned (uns_q),
    .value       (ext_value)
  );

  // Datapath and registered bus / response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= 3'd0;
      addr_q       <= 32'd0;
      size_q       <= MEM_B;
      uns_q        <= 1'b0;
      tag_q        <= '0;
      data_buf     <= 32'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_value_q <= 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else if (rdy) begin
      resp_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          mem_wr_q <= 1'b0;
          if (accept) begin
            addr_q   <= bus.req_addr;
            size_q   <= norm_size(bus.req_size);
            uns_q    <= bus.req_unsigned;
            tag_q    <= bus.req_rob_id;
            data_buf <= bus.req_is_store ? bus.req_data : 32'd0;
            cnt_q    <= 3'd0;
            if (misalign_req) begin
              resp_valid_q <= 1'b1;
              resp_tag_q   <= bus.req_rob_id;
              resp_value_q <= 32'hDEAD_BEEF;
`ifdef MEM_MISALIGN_CHECK_EN
              resp_err_q   <= 1'b1;
`endif
            end else if (!bus.req_is_store) begin
              mem_a_q <= bus.req_addr;
            end
          end
        end
        ST_LOAD: begin
          mem_wr_q <= 1'b0;
          if (!bus.flush) begin
            if (cnt_q != 3'd0) data_buf <= load_buf;
            if (last_done) begin
              resp_valid_q <= 1'b1;
              resp_tag_q   <= tag_q;
              resp_value_q <= ext_value;
            end else begin
              cnt_q <= cnt_nx;
              if (cnt_nx < nbytes) mem_a_q <= addr_q + {29'd0, cnt_nx};
            end
          end
        end
        ST_STORE: begin
          if (last_done) begin
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_tag_q   <= tag_q;
            resp_value_q <= 32'd0;
          end else begin
            mem_a_q    <= addr_q + {29'd0, cnt_q};
            mem_dout_q <= data_buf[{cnt_q[1:0], 3'b000} +: 8];
            // A full I/O buffer parks the current byte without writing it.
            mem_wr_q   <= !io_stall;
            if (!io_stall) cnt_q <= cnt_nx;
          end
        end
        default: mem_wr_q <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
